// File: rtl/time_entry_pkg.sv
// Shared types and constants for the hh:mm:ss entry block.
package time_entry_pkg;

    typedef enum logic [2:0] {
        StSelHr,
        StSelMin,
        StSelSec,
        StOffer,
        StDone
    } state_e;

    localparam int unsigned HR_MAX     = 23;
    localparam int unsigned MS_MAX     = 59;
    localparam int unsigned HR_WEIGHT  = 3600;
    localparam int unsigned MIN_WEIGHT = 60;

endpackage

// File: rtl/time_entry_button_debounce.sv
// Two-flop synchroniser, stability-count debouncer and single-cycle press pulse
// for an active-low push button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_vld;
    logic             r_level;
    logic             r_armed;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    assign w_accept = (r_sync2 != r_level) && (r_cnt == CNT_MAX);
    assign press    = r_press;

    // r_armed only sets once a real (post-reset) released sample is seen, so a
    // button held down through reset release never yields a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_vld   <= 2'b00;
            r_level <= 1'b1;
            r_armed <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_press <= w_accept && r_level && r_armed;
        end
    end

endmodule

// File: rtl/time_entry.sv
// Button-driven hh:mm:ss entry: each field tracks the switches until a press,
// then the total in seconds is offered with a valid/ready handshake.
module time_entry
    import time_entry_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned VAL_W        = 6,
    parameter int unsigned OUT_W        = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] start_num,
    input  logic             button,
    input  logic             edit,
    input  logic             time_ready,
    output logic [OUT_W-1:0] c_out,
    output logic             blink_hr_sig,
    output logic             blink_min_sig,
    output logic             blink_sec_sig,
    output logic             time_valid,
    output logic             done
);

    localparam int unsigned BLK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(CLK_HZ - 1);
    localparam logic [BLK_W-1:0] BLK_HALF = BLK_W'(CLK_HZ / 2);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_press;
    logic [4:0]       r_hr;
    logic [5:0]       r_min;
    logic [5:0]       r_sec;
    logic [4:0]       w_hr_clamp;
    logic [5:0]       w_ms_clamp;
    logic [OUT_W-1:0] r_c_out;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             w_phase;

    button_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .press (w_press)
    );

    always_comb begin
        w_hr_clamp = 5'(start_num);
        w_ms_clamp = 6'(start_num);
        if (32'(start_num) > HR_MAX) begin
            w_hr_clamp = 5'(HR_MAX);
        end
        if (32'(start_num) > MS_MAX) begin
            w_ms_clamp = 6'(MS_MAX);
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StSelHr:  if (w_press)    w_state_next = StSelMin;
            StSelMin: if (w_press)    w_state_next = StSelSec;
            StSelSec: if (w_press)    w_state_next = StOffer;
            StOffer:  if (time_ready) w_state_next = StDone;
            StDone:   if (edit)       w_state_next = StSelHr;
            default:                  w_state_next = StSelHr;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StSelHr;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The active field keeps loading in the press cycle, so the value frozen is
    // the one sampled on that same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hr  <= '0;
            r_min <= '0;
            r_sec <= '0;
        end else begin
            if (r_state == StSelHr)  r_hr  <= w_hr_clamp;
            if (r_state == StSelMin) r_min <= w_ms_clamp;
            if (r_state == StSelSec) r_sec <= w_ms_clamp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_out <= '0;
        end else begin
            r_c_out <= OUT_W'(r_hr) * OUT_W'(HR_WEIGHT)
                     + OUT_W'(r_min) * OUT_W'(MIN_WEIGHT)
                     + OUT_W'(r_sec);
        end
    end

    // Restart on every state change so a newly selected field begins visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
        end else if ((w_state_next != r_state) || (r_blink_cnt == BLK_MAX)) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_phase = (r_blink_cnt >= BLK_HALF);

    always_comb begin
        blink_hr_sig  = 1'b0;
        blink_min_sig = 1'b0;
        blink_sec_sig = 1'b0;
        case (r_state)
            StSelHr:  blink_hr_sig  = w_phase;
            StSelMin: blink_min_sig = w_phase;
            StSelSec: blink_sec_sig = w_phase;
            default:  ;
        endcase
    end

    assign time_valid = (r_state == StOffer);
    assign done       = (r_state == StDone);
    assign c_out      = r_c_out;

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 Parameter CLK_HZ, default 50000000: clock frequency in Hz; blink half-period is CLK_HZ/2 cycles.
REQ-002 Parameter DEBOUNCE_CYC, default 1000000: cycles the synchronised button must stay stable before a level change is accepted.
REQ-003 Parameter VAL_W, default 6: width of the switch input.
REQ-004 Parameter OUT_W, default 17: width of the total-seconds output, minimum 17.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port start_num, input, VAL_W: switch value for the field being edited.
REQ-008 Port button, input, 1: raw, asynchronous, active-low push button.
REQ-009 Port edit, input, 1: active-high request to re-enter editing from DONE.
REQ-010 Port time_ready, input, 1: consumer accepts the offered time.
REQ-011 Port c_out, output, OUT_W: hr*3600 + min*60 + sec.
REQ-012 Ports blink_hr_sig, blink_min_sig, blink_sec_sig, output, 1 each: blank the matching display field while high.
REQ-013 Port time_valid, output, 1: the entered time is offered on c_out.
REQ-014 Port done, output, 1: the entered time has been accepted.

Function
REQ-015 button is synchronised through two flops, then debounced; a press event is a single-cycle pulse on the accepted high-to-low transition.
REQ-016 FSM states: SEL_HR, SEL_MIN, SEL_SEC, OFFER, DONE.
REQ-017 In each SEL state the active field follows start_num every cycle, clamped: hr to a maximum of 23, min and sec to a maximum of 59.
REQ-018 A press event moves SEL_HR to SEL_MIN, SEL_MIN to SEL_SEC and SEL_SEC to OFFER; the field value is frozen at its clamped value in the press cycle.
REQ-019 In OFFER, time_valid is 1 and c_out is stable; time_ready=1 moves the FSM to DONE on the next edge.
REQ-020 In DONE, done is 1 and time_valid is 0; edit=1 moves the FSM to SEL_HR, keeping the field values.
REQ-021 Press events in OFFER and DONE are ignored; edit in any state other than DONE is ignored.
REQ-022 The blink counter counts 0 to CLK_HZ-1 and then wraps; the phase is 1 when count >= CLK_HZ/2.
REQ-023 Only the blink signal of the active SEL field equals the phase; all blink signals are 0 in OFFER and DONE.
REQ-024 The blink counter restarts at 0 on every state change, so a newly active field starts visible.
REQ-025 c_out is registered with one-cycle latency from the field registers; the arithmetic is unsigned OUT_W-bit, and the maximum of 86399 must not overflow.
REQ-026 If a press event and a start_num change fall in the same cycle, the start_num value sampled in that cycle is captured.

Reset
REQ-027 rst low, at any time and in any state, asynchronously sets: FSM to SEL_HR; hr, min and sec to 0; c_out to 0; blink counter to 0; all blink outputs to 0; time_valid and done to 0.
REQ-028 On reset the debouncer reset state is "released" (high), so holding the button through reset release produces no press event.
REQ-029 A reset during OFFER drops time_valid in the same cycle, without waiting for time_ready.

Structure
REQ-030 Package time_entry_pkg holds the FSM state enum, the field limits 23 and 59, and the weights 3600 and 60.
REQ-031 Sub-module button_debounce (parameter DEBOUNCE_CYC; ports clk, rst, button, press) holds the synchroniser, stability counter and edge pulse.
REQ-032 All other logic is in time_entry; there are no latches and no combinational feedback.

Verification
REQ-033 Test parameters are CLK_HZ=20 and DEBOUNCE_CYC=4.
REQ-034 Scenario 1: set start_num=12 and press; set 34 and press; set 56 and press -> time_valid=1 and c_out=45296.
REQ-035 Scenario 2: start_num=63 in each field -> fields clamp to 23/59/59 and c_out=86399, with no overflow.
REQ-036 Scenario 3: button bounce pulses shorter than 4 cycles -> no press event; one stable low -> exactly one advance.
REQ-037 Scenario 4: in OFFER, hold time_ready=0 for 10 cycles and then 1 -> time_valid stays 1, then goes 0 with done=1 the next cycle; an edit pulse then returns the FSM to SEL_HR with c_out unchanged.
REQ-038 Scenario 5: in SEL_MIN, blink_min_sig is 0 for 10 cycles and then 1 for 10 cycles after entry; blink_hr_sig and blink_sec_sig stay 0.
REQ-039 Scenario 6: assert rst low mid-OFFER -> time_valid=0 and c_out=0 immediately; after release the FSM is in SEL_HR and no press occurs with the button held low.
